channel_feature_serializer: RTL and testbench
=============================================

CHANNEL_FEATURE_SERIALIZER -- requirements
Module: channel_feature_serializer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 8, number of parallel bandpower channels (>=2).
REQ-002 SHALL have parameter EW, default 32, width of one channel energy word (unsigned).
REQ-003 SHALL define localparam IW = $clog2(NUM_CHANNELS) and SW = EW + IW.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 frame_ready  input  1  one-cycle pulse from the frame barrier: all channel energies valid.
REQ-007 chan_energy  input  NUM_CHANNELS*EW  flattened energies; channel k at bits [k*EW +: EW].
REQ-008 feat_valid  output  1  feature record valid.
REQ-009 feat_ready  input  1  downstream accepts the record.
REQ-010 feat_total  output  SW  sum of all channel energies.
REQ-011 feat_max  output  EW  largest channel energy.
REQ-012 feat_argmax  output  IW  index of the largest channel.
REQ-013 feat_min / feat_argmin  output  EW / IW  smallest energy and index (present only per REQ-031).
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 overrun_cnt  output  8  count of dropped frames.

Function
REQ-016 SHALL implement FSM with states IDLE, SCAN, HOLD.
REQ-017 IDLE: frame_ready=1 -> snapshot all of chan_energy into an internal register bank, clear accumulators, idx=0, go to SCAN.
REQ-018 SCAN: process exactly one snapshot channel per cycle, idx 0..NUM_CHANNELS-1; after idx=NUM_CHANNELS-1 go to HOLD.
REQ-019 Latency: frame_ready sampled at edge T -> feat_valid high from edge T+NUM_CHANNELS+1 (9 cycles for default).
REQ-020 Accumulation: feat_total = exact sum, width SW, no overflow possible.
REQ-021 Max: update only on strict greater-than; ties keep the lowest index; channel 0 initialises max/argmax.
REQ-022 HOLD: feat_valid=1; all feat_* outputs stable until feat_valid&feat_ready.
REQ-023 HOLD with feat_ready=1 and frame_ready=0 -> IDLE; feat_valid low next cycle.
REQ-024 HOLD with feat_ready=1 and frame_ready=1 same cycle -> new frame accepted, snapshot taken, go directly to SCAN; not an overrun.
REQ-025 frame_ready while SCAN, or HOLD without feat_ready -> frame dropped, snapshot untouched, overrun_cnt += 1, saturating at 255.
REQ-026 Snapshot isolates processing: chan_energy changes after the snapshot edge SHALL NOT affect results.
REQ-027 feat_* outputs SHALL hold the last accepted record while not in HOLD (no glitching to partial results).

Reset
REQ-028 rst SHALL force IDLE, idx=0, feat_valid=0, busy=0, overrun_cnt=0, feat_total=0, feat_max=0, feat_argmax=0, feat_min=0, feat_argmin=0.
REQ-029 rst mid-SCAN or mid-HOLD SHALL abandon the frame; no record is emitted; overrun_cnt cleared.
REQ-030 rst SHALL have priority over frame_ready and feat_ready in the same cycle.

Configuration
REQ-031 Macro FEAT_MIN_EN: defined -> feat_min/feat_argmin ports and min tracking present (update on strict less-than, ties keep lowest index); undefined -> ports and logic absent, all other behaviour identical.

Verification
REQ-032 Energies ch0..7 = 10,50,30,50,5,20,40,15, frame_ready at T, feat_ready=1 -> feat_valid at T+9, total=220, max=50, argmax=1, min=5, argmin=4 (FEAT_MIN_EN).
REQ-033 All energies 0xFFFFFFFF -> total=0x7_FFFFFFF8 (35 bits), argmax=0, argmin=0.
REQ-034 feat_ready=0 for 20 cycles after feat_valid, frame_ready pulsed at cycle 12 of SCAN/HOLD -> outputs stable, overrun_cnt=1, single record delivered.
REQ-035 HOLD with feat_ready=1 and frame_ready=1 same cycle, new energies all 7 -> overrun_cnt unchanged, next record total=56 after 9 cycles.
REQ-036 rst asserted at SCAN idx=4 -> feat_valid never asserts for that frame, busy=0 next cycle, next frame processed normally.
REQ-037 300 dropped frames -> overrun_cnt saturates at 255.

Source files
------------

// File: rtl/channel_feature_serializer.sv
// Snapshots a frame of channel energies, scans one channel per cycle for sum/max, then holds the record for a valid/ready handshake.
// Optional min/argmin tracking and ports are enabled by defining FEAT_MIN_EN.
module channel_feature_serializer #(
  parameter int NUM_CHANNELS = 8,
  parameter int EW = 32,
  localparam int IW = $clog2(NUM_CHANNELS),
  localparam int SW = EW + IW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_ready,
  input  logic [NUM_CHANNELS*EW-1:0] chan_energy,
  output logic                     feat_valid,
  input  logic                     feat_ready,
  output logic [SW-1:0]            feat_total,
  output logic [EW-1:0]            feat_max,
  output logic [IW-1:0]            feat_argmax,
`ifdef FEAT_MIN_EN
  output logic [EW-1:0]            feat_min,
  output logic [IW-1:0]            feat_argmin,
`endif
  output logic                     busy,
  output logic [7:0]               overrun_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t state, state_next;

  logic [EW-1:0] snap [NUM_CHANNELS];
  logic [IW-1:0] idx;
  logic [SW-1:0] acc_total;
  logic [EW-1:0] acc_max;
  logic [IW-1:0] acc_argmax;
`ifdef FEAT_MIN_EN
  logic [EW-1:0] acc_min;
  logic [IW-1:0] acc_argmin;
`endif

  logic          accept;
  logic          drop;
  logic          publish;
  logic          handshake;
  logic          last;
  logic [EW-1:0] word;

  assign word      = snap[idx];
  assign last      = (idx == IW'(NUM_CHANNELS - 1));
  assign handshake = feat_valid && feat_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // HOLD spends its first cycle publishing the finished accumulators, giving NUM_CHANNELS+1 cycles of latency.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    drop       = 1'b0;
    publish    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_ready) begin
          accept     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        drop = frame_ready;
        if (last) state_next = HOLD;
      end
      HOLD: begin
        if (handshake) begin
          if (frame_ready) begin
            accept     = 1'b1;
            state_next = SCAN;
          end else begin
            state_next = IDLE;
          end
        end else begin
          drop    = frame_ready;
          publish = !feat_valid;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NUM_CHANNELS; k++) snap[k] <= chan_energy[k*EW +: EW];
    end
  end

  // Channel 0 seeds the extremes; later channels replace them only on a strict improvement.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      idx        <= '0;
      acc_total  <= '0;
      acc_max    <= '0;
      acc_argmax <= '0;
`ifdef FEAT_MIN_EN
      acc_min    <= '0;
      acc_argmin <= '0;
`endif
    end else if (state == SCAN) begin
      idx <= last ? '0 : idx + IW'(1);
      if (idx == '0) begin
        acc_total  <= SW'(word);
        acc_max    <= word;
        acc_argmax <= '0;
`ifdef FEAT_MIN_EN
        acc_min    <= word;
        acc_argmin <= '0;
`endif
      end else begin
        acc_total <= acc_total + SW'(word);
        if (word > acc_max) begin
          acc_max    <= word;
          acc_argmax <= idx;
        end
`ifdef FEAT_MIN_EN
        if (word < acc_min) begin
          acc_min    <= word;
          acc_argmin <= idx;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      feat_valid  <= 1'b0;
      feat_total  <= '0;
      feat_max    <= '0;
      feat_argmax <= '0;
`ifdef FEAT_MIN_EN
      feat_min    <= '0;
      feat_argmin <= '0;
`endif
    end else if (publish) begin
      feat_valid  <= 1'b1;
      feat_total  <= acc_total;
      feat_max    <= acc_max;
      feat_argmax <= acc_argmax;
`ifdef FEAT_MIN_EN
      feat_min    <= acc_min;
      feat_argmin <= acc_argmin;
`endif
    end else if (state == HOLD && handshake) begin
      feat_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                            overrun_cnt <= '0;
    else if (drop && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
  end

endmodule

// File: tb/tb_channel_feature_serializer.sv
// Scoreboard bench for channel_feature_serializer: directed frames push expected records, a monitor checks each handshake.
module tb_channel_feature_serializer;

  localparam int N  = 8;
  localparam int EW = 32;
  localparam int IW = 3;
  localparam int SW = 35;

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_ready;
  logic [N*EW-1:0] chan_energy;
  logic            feat_valid;
  logic            feat_ready;
  logic [SW-1:0]   feat_total;
  logic [EW-1:0]   feat_max;
  logic [IW-1:0]   feat_argmax;
`ifdef FEAT_MIN_EN
  logic [EW-1:0]   feat_min;
  logic [IW-1:0]   feat_argmin;
`endif
  logic            busy;
  logic [7:0]      overrun_cnt;

  channel_feature_serializer #(.NUM_CHANNELS(N), .EW(EW)) dut (
    .clk(clk), .rst(rst), .frame_ready(frame_ready), .chan_energy(chan_energy),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_total(feat_total),
    .feat_max(feat_max), .feat_argmax(feat_argmax),
`ifdef FEAT_MIN_EN
    .feat_min(feat_min), .feat_argmin(feat_argmin),
`endif
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] total;
    logic [EW-1:0] max;
    logic [IW-1:0] argmax;
    logic [EW-1:0] min;
    logic [IW-1:0] argmin;
  } rec_t;

  rec_t exp_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  localparam logic [N*EW-1:0] FRAME_A   = {32'd15, 32'd40, 32'd20, 32'd5, 32'd50, 32'd30, 32'd50, 32'd10};
  localparam logic [N*EW-1:0] FRAME_MAX = {N{32'hFFFF_FFFF}};
  localparam logic [N*EW-1:0] FRAME_SEQ = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [N*EW-1:0] FRAME_7   = {N{32'd7}};
  localparam logic [N*EW-1:0] FRAME_99  = {N{32'd99}};
  localparam logic [N*EW-1:0] FRAME_PI  = {32'd6, 32'd2, 32'd9, 32'd5, 32'd1, 32'd4, 32'd1, 32'd3};

  function automatic rec_t mk(input logic [SW-1:0] t, input logic [EW-1:0] mx, input logic [IW-1:0] amx,
                              input logic [EW-1:0] mn, input logic [IW-1:0] amn);
    rec_t r;
    r.total = t; r.max = mx; r.argmax = amx; r.min = mn; r.argmin = amn;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame_ready pulse; the frame is snapshotted on the edge inside this task.
  task automatic send_frame(input logic [N*EW-1:0] e, input bit push, input rec_t exp);
    chan_energy = e;
    frame_ready = 1'b1;
    if (push) exp_q.push_back(exp);
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int k;
    bit seen;
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      tick();
      if (feat_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen ? k : 99, exp_lat);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (feat_valid) seen = 1'b1;
    end
    check(name, seen, 1'b0);
  endtask

  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (!rst && feat_valid && feat_ready) begin
        if (exp_q.size() == 0) begin
          check("record_expected", exp_q.size(), 1);
        end else begin
          r = exp_q.pop_front();
          check("rec_total", feat_total, r.total);
          check("rec_max", feat_max, r.max);
          check("rec_argmax", feat_argmax, r.argmax);
`ifdef FEAT_MIN_EN
          check("rec_min", feat_min, r.min);
          check("rec_argmin", feat_argmin, r.argmin);
`endif
        end
      end
    end
  end

  initial begin
    rst = 1'b1; frame_ready = 1'b0; feat_ready = 1'b0; chan_energy = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_valid", feat_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun_cnt, 0);
    check("rst_total", feat_total, 0);
    check("rst_max", feat_max, 0);
    check("rst_argmax", feat_argmax, 0);

    // Basic frame, energies changed right after the snapshot edge.
    feat_ready = 1'b1;
    send_frame(FRAME_A, 1'b1, mk(35'd220, 32'd50, 3'd1, 32'd5, 3'd4));
    chan_energy = FRAME_99;
    check("scan_busy", busy, 1);
    wait_valid("latency_a", 9);
    tick();
    check("post_hs_valid", feat_valid, 0);
    check("idle_hold_total", feat_total, 220);
    check("idle_hold_argmax", feat_argmax, 1);

    // Full-scale energies must not overflow the total.
    send_frame(FRAME_MAX, 1'b1, mk(35'h7_FFFF_FFF8, 32'hFFFF_FFFF, 3'd0, 32'hFFFF_FFFF, 3'd0));
    wait_valid("latency_max", 9);
    tick();

    // Backpressure with a dropped frame part way through HOLD.
    feat_ready = 1'b0;
    send_frame(FRAME_SEQ, 1'b1, mk(35'd36, 32'd8, 3'd7, 32'd1, 3'd0));
    wait_valid("latency_seq", 9);
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        chan_energy = FRAME_99;
        frame_ready = 1'b1;
      end
      tick();
      frame_ready = 1'b0;
      check("stall_total", feat_total, 36);
      check("stall_valid", feat_valid, 1);
    end
    check("stall_overrun", overrun_cnt, 1);
    feat_ready = 1'b1;
    tick();
    check("stall_release_valid", feat_valid, 0);
    check("stall_release_busy", busy, 0);
    expect_quiet("single_record", 12);

    // Back-to-back: new frame accepted on the handshake cycle.
    feat_ready = 1'b0;
    send_frame(FRAME_SEQ, 1'b1, mk(35'd36, 32'd8, 3'd7, 32'd1, 3'd0));
    wait_valid("latency_b2b_first", 9);
    feat_ready = 1'b1;
    send_frame(FRAME_7, 1'b1, mk(35'd56, 32'd7, 3'd0, 32'd7, 3'd0));
    check("b2b_busy", busy, 1);
    check("b2b_overrun", overrun_cnt, 1);
    wait_valid("latency_b2b_second", 9);
    check("b2b_total_live", feat_total, 56);
    tick();

    // Continuous drops saturate the overrun counter.
    feat_ready = 1'b0;
    send_frame(FRAME_7, 1'b1, mk(35'd56, 32'd7, 3'd0, 32'd7, 3'd0));
    frame_ready = 1'b1;
    repeat (300) tick();
    frame_ready = 1'b0;
    check("overrun_sat", overrun_cnt, 255);
    check("sat_valid", feat_valid, 1);
    feat_ready = 1'b1;
    tick();
    tick();

    // Reset in the middle of SCAN abandons the frame.
    send_frame(FRAME_PI, 1'b0, '0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", feat_valid, 0);
    check("mid_rst_overrun", overrun_cnt, 0);
    check("mid_rst_total", feat_total, 0);
    expect_quiet("mid_rst_no_record", 15);
    send_frame(FRAME_PI, 1'b1, mk(35'd31, 32'd9, 3'd5, 32'd1, 3'd1));
    wait_valid("latency_after_rst", 9);
    repeat (3) tick();

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
